// File: rtl/cam_dvp_pkg.sv
// Shared types and constants for the DVP camera source: FSM states, colour-bar table
// and the on-board (VGA) timing defaults.
package cam_dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_e;

  localparam int BOARD_H_ACTIVE    = 640;
  localparam int BOARD_H_BLANK     = 144;
  localparam int BOARD_V_ACTIVE    = 480;
  localparam int BOARD_VSYNC_LINES = 3;
  localparam int BOARD_V_BACK      = 17;
  localparam int BOARD_V_FRONT     = 10;

  // RGB565 colours of the eight vertical bars, left to right.
  function automatic logic [15:0] cbar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/cam_pclk_div.sv
// Pixel-clock divider: Pclk toggles every PCLK_DIV clk cycles while run is high,
// and is held low otherwise. Ticks mark the clk edge on which Pclk will change.
module cam_pclk_div #(
  parameter int PCLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic pclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          pclk_q;
  logic          half_done;

  assign half_done = run && (cnt_q == CW'(PCLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_q  <= '0;
      pclk_q <= 1'b0;
    end else if (half_done) begin
      cnt_q  <= '0;
      pclk_q <= ~pclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign pclk_o      = pclk_q;
  assign rise_tick_o = half_done && !pclk_q;
  assign fall_tick_o = half_done && pclk_q;

endmodule

// File: rtl/camara_dvp_gen.sv
// OV7670-style DVP frame source (RGB565, high byte first). Define CAM_COLORBAR_EN for
// eight vertical colour bars; otherwise each line carries a byte ramp.
module camara_dvp_gen #(
  parameter int H_ACTIVE    = 8,
  parameter int H_BLANK     = 4,
  parameter int V_ACTIVE    = 4,
  parameter int VSYNC_LINES = 1,
  parameter int V_BACK      = 1,
  parameter int V_FRONT     = 1,
  parameter int PCLK_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       Reset,
  input  logic       PWDN,
  output logic       Vsync,
  output logic       Href,
  output logic       Pclk,
  output logic [7:0] Imagen,
  output logic       frame_done
);

  import cam_dvp_pkg::*;

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int BW    = (LINE > 1) ? $clog2(LINE) : 1;
  localparam int VM1   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VM2   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX  = (VM1 > VM2) ? VM1 : VM2;
  localparam int LW    = (VMAX > 1) ? $clog2(VMAX) : 1;
  localparam int BAR_W = H_ACTIVE / 8;

  state_e        state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  logic          vsync_q, href_q, done_q, done_d, href_d, wrap;
  logic [7:0]    img_q;
  logic          rst_c, run, fall_tick, rise_tick_unused;

  function automatic logic [LW-1:0] last_line(input state_e s);
    case (s)
      VSYNC:   return LW'(VSYNC_LINES - 1);
      VBACK:   return LW'(V_BACK - 1);
      ACTIVE:  return LW'(V_ACTIVE - 1);
      default: return LW'(V_FRONT - 1);
    endcase
  endfunction

  function automatic logic [7:0] pattern_byte(input logic [BW-1:0] b);
`ifdef CAM_COLORBAR_EN
    logic [BW-1:0] bar;
    logic [15:0]   col;
    bar = (b >> 1) / BW'(BAR_W);
    col = cbar_color(3'(bar));
    return b[0] ? col[7:0] : col[15:8];
`else
    return 8'(b);
`endif
  endfunction

  // The capture-side Reset is active-low and behaves exactly like rst.
  assign rst_c = rst || !Reset;
  assign run   = !PWDN && ((state_q != IDLE) || enable);

  cam_pclk_div #(.PCLK_DIV(PCLK_DIV)) u_div (
    .clk        (clk),
    .rst        (rst_c),
    .run        (run),
    .pclk_o     (Pclk),
    .rise_tick_o(rise_tick_unused),
    .fall_tick_o(fall_tick)
  );

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    line_d  = line_q;
    done_d  = 1'b0;
    wrap    = (byte_q == BW'(LINE - 1));
    if (state_q == IDLE) begin
      state_d = VSYNC;
      byte_d  = '0;
      line_d  = '0;
    end else begin
      byte_d = wrap ? '0 : byte_q + BW'(1);
      if (wrap) begin
        if (line_q == last_line(state_q)) begin
          line_d = '0;
          case (state_q)
            VSYNC:   state_d = VBACK;
            VBACK:   state_d = ACTIVE;
            ACTIVE:  state_d = VFRONT;
            VFRONT: begin
              done_d  = 1'b1;
              state_d = enable ? VSYNC : IDLE;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          line_d = line_q + LW'(1);
        end
      end
    end
    href_d = (state_d == ACTIVE) && (byte_d < BW'(2 * H_ACTIVE));
  end

  // Everything visible on the bus moves only on the Pclk falling edge.
  always_ff @(posedge clk) begin
    if (rst_c) begin
      state_q <= IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      img_q   <= 8'h00;
      done_q  <= 1'b0;
    end else if (PWDN) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      img_q   <= 8'h00;
      done_q  <= 1'b0;
    end else if (fall_tick) begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      vsync_q <= (state_d == VSYNC);
      href_q  <= href_d;
      img_q   <= href_d ? pattern_byte(byte_d) : 8'h00;
      done_q  <= done_d;
    end else begin
      done_q  <= 1'b0;
    end
  end

  assign Vsync      = vsync_q;
  assign Href       = href_q;
  assign Imagen     = img_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_camara_dvp_gen.sv
// Directed bench for camara_dvp_gen with default timing (frame = 140 Pclk = 280 clk).
// Honours CAM_COLORBAR_EN when choosing expected pixel bytes.
module tb_camara_dvp_gen;

`ifdef CAM_COLORBAR_EN
  localparam bit BAR_MODE = 1'b1;
`else
  localparam bit BAR_MODE = 1'b0;
`endif

  logic       clk, rst, enable, Reset, PWDN;
  logic       Vsync, Href, Pclk, frame_done;
  logic [7:0] Imagen;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    int         cyc;
    logic       vs;
    logic       hr;
    logic       pc;
    logic       fd;
    logic [7:0] ramp;
    logic [7:0] bar;
  } vec_t;

  vec_t       vt [18];
  logic [7:0] bar_line [16];

  camara_dvp_gen dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .Reset     (Reset),
    .PWDN      (PWDN),
    .Vsync     (Vsync),
    .Href      (Href),
    .Pclk      (Pclk),
    .Imagen    (Imagen),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {Vsync, Href, Pclk, frame_done, Imagen};
  endfunction

  initial begin
    int   n, line, b, hr_rises, vs_pclks;
    logic nz, prev_hr, e_vs, e_hr;
    logic [7:0] e_img;

    bar_line = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    // Cumulative timeline from IDLE; E0 = first Pclk rise, E1 = first fall (VSYNC).
    vt[0]  = '{1'b1,   1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00}; // E0
    vt[1]  = '{1'b1,   1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // E1
    vt[2]  = '{1'b1,  39, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00}; // E40
    vt[3]  = '{1'b1,   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // E41 VBACK
    vt[4]  = '{1'b1,  40, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF}; // E81 ACTIVE byte0
    vt[5]  = '{1'b1,   1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF}; // E82
    vt[6]  = '{1'b1,   1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'hFF}; // E83 byte1
    vt[7]  = '{1'b1,  12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07, 8'hE0}; // E95 byte7
    vt[8]  = '{1'b1,  18, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // E113 blank
    vt[9]  = '{1'b1,   8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF}; // E121 line1 byte0
    vt[10] = '{1'b1,   9, 1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 8'h07}; // E130 byte4
    vt[11] = '{1'b1, 111, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // E241 VFRONT
    vt[12] = '{1'b1,  39, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00}; // E280
    vt[13] = '{1'b1,   1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00}; // E281 frame_done
    vt[14] = '{1'b1,   1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00}; // E282
    vt[15] = '{1'b0, 279, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00}; // E561 last frame ends
    vt[16] = '{1'b0,   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // E562 idle
    vt[17] = '{1'b0,  50, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // still idle

    // Reset dominates even with enable asserted.
    rst = 1'b1; Reset = 1'b1; enable = 1'b1; PWDN = 1'b0;
    tick(3);
    chk("reset_outputs", 32'(outs()), 32'h0);
    enable = 1'b0;
    tick(1);
    rst = 1'b0;
    nz = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      nz = nz | (|outs());
    end
    chk("idle_static_100clk", 32'(nz), 32'h0);

    for (int i = 0; i < 18; i++) begin
      enable = vt[i].en;
      tick(vt[i].cyc);
      chk($sformatf("vec%0d.vsync", i), 32'(Vsync), 32'(vt[i].vs));
      chk($sformatf("vec%0d.href", i), 32'(Href), 32'(vt[i].hr));
      chk($sformatf("vec%0d.pclk", i), 32'(Pclk), 32'(vt[i].pc));
      chk($sformatf("vec%0d.frame_done", i), 32'(frame_done), 32'(vt[i].fd));
      chk($sformatf("vec%0d.imagen", i), 32'(Imagen), 32'(BAR_MODE ? vt[i].bar : vt[i].ramp));
    end

    // Full frame sampled on every Pclk rise against a line/byte timing model.
    enable = 1'b1;
    tick(1);
    hr_rises = 0; vs_pclks = 0; prev_hr = 1'b0;
    for (int p = 0; p < 140; p++) begin
      tick(2);
      line  = p / 20;
      b     = p % 20;
      e_vs  = (line == 0);
      e_hr  = (line >= 2) && (line <= 5) && (b < 16);
      e_img = e_hr ? (BAR_MODE ? bar_line[b] : 8'(b)) : 8'h00;
      chk($sformatf("frame.p%0d.pclk", p), 32'(Pclk), 32'h1);
      chk($sformatf("frame.p%0d.vsync", p), 32'(Vsync), 32'(e_vs));
      chk($sformatf("frame.p%0d.href", p), 32'(Href), 32'(e_hr));
      chk($sformatf("frame.p%0d.imagen", p), 32'(Imagen), 32'(e_img));
      if (Href && !prev_hr) hr_rises++;
      if (Vsync) vs_pclks++;
      prev_hr = Href;
    end
    chk("href_pulses", 32'(hr_rises), 32'd4);
    chk("vsync_pclks", 32'(vs_pclks), 32'd20);
    tick(1);
    chk("frame_done_end", 32'(frame_done), 32'h1);
    n = 0;
    do begin tick(1); n++; end while (!frame_done && n < 600);
    chk("frame_done_period", 32'(n), 32'd280);

    // PWDN in the middle of ACTIVE line 2 aborts at once, with no frame_done.
    tick(176);
    chk("pwdn_pre_href", 32'(Href), 32'h1);
    chk("pwdn_pre_imagen", 32'(Imagen), 32'(BAR_MODE ? 8'hF8 : 8'h08));
    PWDN = 1'b1;
    tick(1);
    chk("pwdn_abort_outputs", 32'(outs()), 32'h0);
    nz = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      nz = nz | (|outs());
    end
    chk("pwdn_hold_with_enable", 32'(nz), 32'h0);
    PWDN = 1'b0;
    tick(2);
    chk("pwdn_restart_vsync", 32'(Vsync), 32'h1);
    n = 0;
    while (Vsync && n < 100) begin tick(1); n++; end
    chk("pwdn_restart_vsync_clks", 32'(n), 32'd40);

    // enable drops during VBACK: the frame still completes once.
    enable = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (!frame_done && n < 600);
    chk("en_off_frame_done_clks", 32'(n), 32'd240);
    nz = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      nz = nz | (|outs());
    end
    chk("en_off_idle_static", 32'(nz), 32'h0);

    // Camera Reset (active-low) mid-frame.
    enable = 1'b1;
    tick(101);
    Reset = 1'b0;
    tick(1);
    chk("cam_reset_outputs", 32'(outs()), 32'h0);
    nz = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      nz = nz | (|outs());
    end
    chk("cam_reset_hold", 32'(nz), 32'h0);
    Reset = 1'b1;
    tick(2);
    chk("cam_reset_restart_vsync", 32'(Vsync), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
